// File: rtl/rs_pkg.sv
// Shared reservation-station sizing and types, used by the allocation tracker
// and the issue selector.
package rs_pkg;

  localparam int RS_SIZE  = 4;
  localparam int RS_IDX_W = $clog2(RS_SIZE);
  localparam int RS_AGE_W = 2;

  typedef logic [RS_AGE_W-1:0] age_t;
  typedef logic [RS_IDX_W-1:0] rs_idx_t;

endpackage

// File: rtl/rs_free_pick.sv
// Lowest-index free-entry finder: find-first-set over the inverted busy vector,
// giving a one-hot strobe, a binary index and a found flag.
module rs_free_pick #(
  parameter int SIZE  = 4,
  parameter int IDX_W = 2
) (
  input  logic [SIZE-1:0]  busy_i,
  output logic [SIZE-1:0]  sel_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    sel_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        found_o  = 1'b1;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/rs_alloc_tracker.sv
// Reservation-station allocation tracker: accepts dispatched instructions, picks a
// free entry, keeps per-entry saturating ages and frees entries on issue grants.
module rs_alloc_tracker
  import rs_pkg::*;
#(
  parameter int SIZE  = RS_SIZE,
  parameter int IDX_W = RS_IDX_W,
  parameter int AGE_W = RS_AGE_W
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  flush_i,
  input  logic                  dispatch_valid_i,
  output logic                  dispatch_ready_o,
  output logic [SIZE-1:0]       alloc_sel_o,
  output logic [IDX_W-1:0]      alloc_idx_o,
  output logic                  allocate_o,
  input  logic [SIZE-1:0]       issue_sel_i,
  output logic [SIZE-1:0]       entry_free_o,
  output logic [SIZE*AGE_W-1:0] age_o,
  output logic [IDX_W:0]        count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  logic [AGE_W-1:0] age_q [SIZE];
  logic [AGE_W-1:0] age_d [SIZE];
  logic [IDX_W:0]   count_q, count_d;
  logic             allocate_q, allocate_d;
  logic             err_q, err_d;

  logic [SIZE-1:0]  busy_s;
  logic [SIZE-1:0]  release_s;
  logic [SIZE-1:0]  pick_sel_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_found_s;
  logic             accept_s;
  logic             bad_release_s;
  logic [IDX_W:0]   rel_cnt_s;

  // An entry is busy exactly when its age is non-zero.
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < SIZE; i++) begin
      busy_s[i] = (age_q[i] != '0);
    end
  end

  rs_free_pick #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_free_pick (
    .busy_i  (busy_s),
    .sel_o   (pick_sel_s),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // Handshake and payload strobe; pick uses registered busy so same-cycle releases are not reused.
  always_comb begin
    full_o           = (count_q == (IDX_W+1)'(SIZE));
    empty_o          = (count_q == '0);
    dispatch_ready_o = reset_ni & ~full_o & ~flush_i & pick_found_s;
    accept_s         = dispatch_valid_i & dispatch_ready_o;
    if (accept_s) begin
      alloc_sel_o = pick_sel_s;
      alloc_idx_o = pick_idx_s;
    end else begin
      alloc_sel_o = '0;
      alloc_idx_o = '0;
    end
  end

  // Next-state for ages, occupancy count and sticky error; flush overrides everything but err.
  always_comb begin
    release_s     = issue_sel_i & busy_s;
    bad_release_s = |(issue_sel_i & ~busy_s);
    rel_cnt_s     = '0;
    for (int i = 0; i < SIZE; i++) begin
      rel_cnt_s = rel_cnt_s + {{IDX_W{1'b0}}, release_s[i]};
    end
    for (int i = 0; i < SIZE; i++) begin
      age_d[i] = age_q[i];
    end
    count_d    = count_q;
    allocate_d = 1'b0;
    err_d      = err_q;
    if (flush_i) begin
      for (int i = 0; i < SIZE; i++) begin
        age_d[i] = '0;
      end
      count_d = '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (release_s[i]) begin
          age_d[i] = '0;
        end else if (accept_s && pick_sel_s[i]) begin
          age_d[i] = AGE_ONE;
        end else if (accept_s && busy_s[i] && (age_q[i] != AGE_MAX)) begin
          age_d[i] = age_q[i] + AGE_ONE;
        end else begin
          age_d[i] = age_q[i];
        end
      end
      count_d    = count_q + {{IDX_W{1'b0}}, accept_s} - rel_cnt_s;
      allocate_d = accept_s;
      err_d      = err_q | bad_release_s;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < SIZE; i++) begin
        age_q[i] <= '0;
      end
      count_q    <= '0;
      allocate_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        age_q[i] <= age_d[i];
      end
      count_q    <= count_d;
      allocate_q <= allocate_d;
      err_q      <= err_d;
    end
  end

  // Output view of the registered state.
  always_comb begin
    age_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      age_o[i*AGE_W +: AGE_W] = age_q[i];
    end
    entry_free_o = ~busy_s;
    count_o      = count_q;
    allocate_o   = allocate_q;
    err_o        = err_q;
  end

endmodule
